// File: rtl/phy_pkg.sv
// phy_pkg: shared PHY constants (comma character, byte width) and receiver state encoding
package phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} sp_state_e;
endpackage

// File: rtl/sp_comma_aligner.sv
// sp_comma_aligner: comma hunt/lock FSM; ports clk_8f, reset, nxt (byte completed by current bit) -> boundary (8th bit of a locked byte), locked
module sp_comma_aligner
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT,
  parameter int ALIGN_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] nxt,
  output logic              boundary,
  output logic              locked
);
  sp_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic hit, last;
  assign hit = nxt == COMMA;
  assign last = bit_cnt_q == 3'd7;
  assign locked = state_q == ACTIVE;
  assign boundary = locked && last;
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      SEARCH: begin
        bit_cnt_d = 3'd0;
        if (hit) begin
          comma_cnt_d = 4'd1;
          state_d = (ALIGN_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: if (last) begin
        comma_cnt_d = hit ? comma_cnt_q + 4'd1 : 4'd0;
        state_d = !hit ? SEARCH : (comma_cnt_d == 4'(ALIGN_COUNT)) ? ACTIVE : ALIGN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q <= SEARCH;
      bit_cnt_q <= 3'd0;
      comma_cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end
endmodule

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: MSB-first deserializer with comma lock; ports clk_8f, reset, data_inS -> data_outP, valid_out, byte_stb, active, byte_count (only with SP_STATS_EN)
module serial_to_parallel_rx
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT,
  parameter int ALIGN_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_inS,
  output logic [BYTE_W-1:0] data_outP,
  output logic              valid_out,
  output logic              byte_stb,
`ifdef SP_STATS_EN
  output logic [15:0]       byte_count,
`endif
  output logic              active
);
  logic [BYTE_W-1:0] sr_q, sr_d, data_q, data_d, nxt;
  logic valid_q, valid_d, stb_q, stb_d, boundary, data_byte;
  assign nxt = {sr_q[BYTE_W-2:0], data_inS};
  assign data_byte = boundary && nxt != COMMA;
  sp_comma_aligner #(.COMMA(COMMA), .ALIGN_COUNT(ALIGN_COUNT)) u_aligner (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .nxt     (nxt),
    .boundary(boundary),
    .locked  (active)
  );
  always_comb begin
    sr_d = nxt;
    stb_d = boundary;
    valid_d = boundary ? data_byte : valid_q;
    data_d = data_byte ? nxt : data_q;
  end
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      stb_q <= stb_d;
    end
  end
  assign data_outP = data_q;
  assign valid_out = valid_q;
  assign byte_stb = stb_q;
`ifdef SP_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (data_byte && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk_8f) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign byte_count = cnt_q;
`endif
endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Receive-side deserializer in the PHY datapath. It sits directly downstream of the serializer and consumes its MSB-first serial bit stream, in which idle bytes are sent as the comma 0xBC. The block finds byte alignment by locking onto a run of commas. It then delivers 8-bit parallel bytes with a valid flag, dropping idle commas.

## Interface
- COMMA, 8'hBC, idle/alignment character.
- ALIGN_COUNT, 4, consecutive aligned commas required to declare lock (range 1..15).

- clk_8f  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge of clk_8f.
- data_inS  input  1  serial data, MSB of each byte first.
- data_outP  output  8  last received non-comma byte.
- valid_out  output  1  data_outP holds a data byte received in the current byte slot.
- byte_stb  output  1  one-cycle pulse at each byte boundary while locked.
- active  output  1  alignment locked.
- byte_count  output  16  data bytes received; present only with SP_STATS_EN.

## Operation
- Shift register: sr <= {sr[6:0], data_inS} every cycle in every state, except while reset is high. nxt = {sr[6:0], data_inS} is the byte completed by the current bit.
- FSM states: SEARCH, ALIGN, ACTIVE. Reset state is SEARCH.
- SEARCH:
  - Bit-by-bit compare of nxt against COMMA.
  - On a match: bit_cnt <= 0, comma_cnt <= 1. If ALIGN_COUNT==1, go directly to ACTIVE; otherwise go to ALIGN.
- ALIGN:
  - bit_cnt counts 0..7 and wraps.
  - When bit_cnt==7 and nxt==COMMA: comma_cnt++. When comma_cnt reaches ALIGN_COUNT, go to ACTIVE.
  - When bit_cnt==7 and nxt!=COMMA: comma_cnt <= 0, go to SEARCH.
- ACTIVE:
  - bit_cnt continues wrapping; active=1.
  - At bit_cnt==7: byte_stb=1. If nxt!=COMMA, data_outP <= nxt and valid_out <= 1. If nxt==COMMA, valid_out <= 0 and data_outP holds its value.
- ACTIVE is left only by reset. Loss-of-lock detection is out of scope, because uncoded data cannot reveal misalignment.
- Reset values: data_outP=0, valid_out=0, byte_stb=0, active=0, byte_count=0, sr=0, bit_cnt=0, comma_cnt=0, state=SEARCH.
- Reset asserted mid-byte or mid-lock aborts immediately. Lock must then be reacquired from SEARCH.

## Timing
- Latency: when the 8th bit of a byte is sampled on edge N, data_outP, valid_out and byte_stb all update on edge N.
- data_outP and valid_out are held for 8 cycles, until the next boundary. A downstream clk_f-domain consumer may sample them anywhere in that window.
- byte_stb is high exactly 1 cycle in every 8 while active; it is never high outside ACTIVE.
- active rises on the edge that completes the ALIGN_COUNT-th comma. The first byte_stb follows 8 cycles later.
- Minimum time from reset release to first data byte: 8·ALIGN_COUNT + 8 cycles.

## Configuration
- SP_STATS_EN defined:
  - byte_count port and register are present.
  - Increments by 1 on each boundary where valid_out is set.
  - Saturates at 16'hFFFF; cleared by reset.
- SP_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package phy_pkg:
  - COMMA_DEFAULT = 8'hBC.
  - The state enum {SEARCH, ALIGN, ACTIVE}, 2-bit encoding.
  - BYTE_W = 8.
- One natural sub-module: sp_comma_aligner, which holds the FSM, bit_cnt, comma_cnt and the comma compare, and outputs boundary and lock signals. The top level owns sr, the output registers and the stats counter.

## Test plan
- Reset: hold reset for 3 cycles with data_inS toggling -> every output is 0, active=0.
- Lock and data: 4×0xBC, then 0x5A, then 0xC3, MSB first -> active rises on the 32nd bit; data_outP=0x5A with valid_out=1 after bit 40; data_outP=0xC3 after bit 48.
- Misaligned start: 3 junk bits 101, then 4×0xBC, then 0x11 -> lock at the correct boundary; 0x11 is delivered with valid_out=1.
- Insufficient commas: 3×0xBC, then 0x77, then 4×0xBC, then 0x22 -> no lock after 0x77 (back to SEARCH), lock after the second run, 0x22 delivered. 0x77 is never output.
- Idle in ACTIVE: after lock send 0x33, 0xBC, 0x44 -> valid_out is 1, then 0, then 1; data_outP holds 0x33 during the idle slot; byte_stb pulses every 8 cycles.
- Reset mid-operation (SP_STATS_EN): lock, send 5 data bytes (byte_count=5), assert reset mid-byte -> byte_count=0 and active=0; relock required before any further output.
